// File: rtl/ahb_mtx_req_stage.sv
// Request stage for one master port of an AHB bus matrix.
// A transfer accepted from the master is presented to the output arbiters
// either live or, when no grant is available yet, from hold registers until
// it is granted. Ready/response from the granted output are returned to the
// master only while this port owns the output data phase.
module ahb_mtx_req_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  active_addr,
    input  logic                  active_data,
    input  logic                  HREADYM,
    input  logic                  HRESPM,
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic [1:0]            HTRANSM,
    output logic                  HWRITEM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HPROTM,
    output logic                  HMASTLOCKM,
    output logic                  trans_pend,
    output logic                  HREADYOUTS,
    output logic                  HRESPS
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    logic                  new_trans;
    logic                  grant;
    logic                  err_cancel;

    logic                  hold_tran_q;
    logic                  hold_tran_d;
    logic                  data_pend_q;
    logic                  data_pend_d;

    logic [ADDR_WIDTH-1:0] haddr_q;
    logic [1:0]            htrans_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [2:0]            hburst_q;
    logic [3:0]            hprot_q;
    logic                  hmastlock_q;

    // A selected NONSEQ/SEQ accepted on the master bus; BUSY and IDLE never qualify.
    assign new_trans = HSELS & HTRANSS[1] & HREADYS;
    // The output arbiter takes whatever this port presents in this cycle.
    assign grant     = active_addr & HREADYM;
    // First ERROR cycle with the master backing off: drop the pending request.
    assign err_cancel = HRESPM & ~HREADYM & HREADYS &
                        (~HSELS | (HTRANSS == TRANS_IDLE));

    // Hold flag: a new transfer that is not granted directly must be held; a
    // grant of the held transfer releases it unless another one arrives with it.
    always_comb begin
        hold_tran_d = hold_tran_q;
        if (err_cancel) begin
            hold_tran_d = 1'b0;
        end else if (new_trans) begin
            hold_tran_d = hold_tran_q | ~grant;
        end else if (grant) begin
            hold_tran_d = 1'b0;
        end
    end

    // Data-phase pending: a granted active transfer owes the master a response.
    always_comb begin
        data_pend_d = data_pend_q;
        if (grant & HTRANSM[1]) begin
            data_pend_d = 1'b1;
        end else if (active_data & HREADYM) begin
            data_pend_d = 1'b0;
        end
    end

    // State flags and address-phase hold registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_tran_q <= 1'b0;
            data_pend_q <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= TRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hburst_q    <= 3'b000;
            hprot_q     <= 4'b0000;
            hmastlock_q <= 1'b0;
        end else begin
            hold_tran_q <= hold_tran_d;
            data_pend_q <= data_pend_d;
            if (new_trans) begin
                haddr_q     <= HADDRS;
                htrans_q    <= HTRANSS;
                hwrite_q    <= HWRITES;
                hsize_q     <= HSIZES;
                hburst_q    <= HBURSTS;
                hprot_q     <= HPROTS;
                hmastlock_q <= HMASTLOCKS;
            end
        end
    end

    // Address mux: held transfer takes precedence; a held SEQ has lost its
    // burst context at the output, so it restarts as NONSEQ INCR.
    always_comb begin
        HADDRM     = HADDRS;
        HTRANSM    = HSELS ? HTRANSS : TRANS_IDLE;
        HWRITEM    = HWRITES;
        HSIZEM     = HSIZES;
        HBURSTM    = HBURSTS;
        HPROTM     = HPROTS;
        HMASTLOCKM = HMASTLOCKS;
        if (hold_tran_q) begin
            HADDRM     = haddr_q;
            HTRANSM    = htrans_q;
            HWRITEM    = hwrite_q;
            HSIZEM     = hsize_q;
            HBURSTM    = hburst_q;
            HPROTM     = hprot_q;
            HMASTLOCKM = hmastlock_q;
            if (htrans_q == TRANS_SEQ) begin
                HTRANSM = TRANS_NONSEQ;
                HBURSTM = BURST_INCR;
            end
        end
    end

    // Request is visible in the master's own address cycle.
    assign trans_pend = hold_tran_q | new_trans;

    // Master-side ready/response.
    assign HREADYOUTS = active_data ? HREADYM :
                        ((hold_tran_q | data_pend_q) ? 1'b0 : 1'b1);
    assign HRESPS     = active_data ? HRESPM : 1'b0;

endmodule

// File: tb/tb_ahb_mtx_req_stage.sv
// Directed bench for ahb_mtx_req_stage: drives inputs just after each rising
// edge and checks the combinational outputs before the next one.
module tb_ahb_mtx_req_stage;

    localparam int AW = 32;

    logic          HCLK;
    logic          HRESETn;
    logic          HSELS;
    logic [AW-1:0] HADDRS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [3:0]    HPROTS;
    logic          HMASTLOCKS;
    logic          HREADYS;
    logic          active_addr;
    logic          active_data;
    logic          HREADYM;
    logic          HRESPM;
    logic [AW-1:0] HADDRM;
    logic [1:0]    HTRANSM;
    logic          HWRITEM;
    logic [2:0]    HSIZEM;
    logic [2:0]    HBURSTM;
    logic [3:0]    HPROTM;
    logic          HMASTLOCKM;
    logic          trans_pend;
    logic          HREADYOUTS;
    logic          HRESPS;

    int n_cmp = 0;
    int n_mis = 0;

    ahb_mtx_req_stage #(.ADDR_WIDTH(AW)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSELS       (HSELS),
        .HADDRS      (HADDRS),
        .HTRANSS     (HTRANSS),
        .HWRITES     (HWRITES),
        .HSIZES      (HSIZES),
        .HBURSTS     (HBURSTS),
        .HPROTS      (HPROTS),
        .HMASTLOCKS  (HMASTLOCKS),
        .HREADYS     (HREADYS),
        .active_addr (active_addr),
        .active_data (active_data),
        .HREADYM     (HREADYM),
        .HRESPM      (HRESPM),
        .HADDRM      (HADDRM),
        .HTRANSM     (HTRANSM),
        .HWRITEM     (HWRITEM),
        .HSIZEM      (HSIZEM),
        .HBURSTM     (HBURSTM),
        .HPROTM      (HPROTM),
        .HMASTLOCKM  (HMASTLOCKM),
        .trans_pend  (trans_pend),
        .HREADYOUTS  (HREADYOUTS),
        .HRESPS      (HRESPS)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0;
        HSIZES = 3'd0; HBURSTS = 3'd0; HPROTS = 4'd0; HMASTLOCKS = 1'b0;
        HREADYS = 1'b1; active_addr = 1'b0; active_data = 1'b0;
        HREADYM = 1'b1; HRESPM = 1'b0;
    endtask

    task automatic master(input logic sel, input logic [1:0] tr, input logic [31:0] addr,
                          input logic [2:0] burst, input logic lock, input logic rdy);
        HSELS = sel; HTRANSS = tr; HADDRS = addr; HBURSTS = burst;
        HMASTLOCKS = lock; HREADYS = rdy;
    endtask

    initial begin
        bus_idle();
        HRESETn = 1'b0;
        #3;
        chk("rst_htrans", HTRANSM, 2'b00);
        chk("rst_pend", trans_pend, 1'b0);
        chk("rst_ready", HREADYOUTS, 1'b1);
        chk("rst_resp", HRESPS, 1'b0);
        edge_step();
        HRESETn = 1'b1;

        // Direct grant: NONSEQ 0x1000 granted in its own address cycle.
        master(1, 2'b10, 32'h1000, 3'd0, 0, 1);
        HWRITES = 1'b1; HSIZES = 3'd2; HPROTS = 4'h3;
        active_addr = 1; HREADYM = 1;
        #1;
        chk("d_addr", HADDRM, 32'h1000);
        chk("d_trans", HTRANSM, 2'b10);
        chk("d_write", HWRITEM, 1'b1);
        chk("d_pend", trans_pend, 1'b1);
        edge_step();
        master(0, 2'b00, 32'h0, 3'd0, 0, 1);
        HWRITES = 0; HSIZES = 0; HPROTS = 0; active_addr = 0;
        #1;
        chk("d_nohold", trans_pend, 1'b0);
        chk("d_datapend_rdy", HREADYOUTS, 1'b0);
        active_data = 1; HREADYM = 0;
        #1;
        chk("d_wait_rdy", HREADYOUTS, 1'b0);
        HREADYM = 1;
        #1;
        chk("d_done_rdy", HREADYOUTS, 1'b1);
        edge_step();
        active_data = 0;
        #1;
        chk("d_after_rdy", HREADYOUTS, 1'b1);

        // Held transfer: NONSEQ 0x2000 waits three cycles for grant.
        master(1, 2'b10, 32'h2000, 3'd0, 0, 1);
        #1;
        chk("h_req", trans_pend, 1'b1);
        edge_step();
        master(0, 2'b00, 32'hDEAD, 3'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("h_pend", trans_pend, 1'b1);
            chk("h_rdy", HREADYOUTS, 1'b0);
            chk("h_addr", HADDRM, 32'h2000);
            chk("h_trans", HTRANSM, 2'b10);
            if (i < 2) edge_step();
        end
        active_addr = 1; HREADYM = 1;
        #1;
        chk("h_grant_addr", HADDRM, 32'h2000);
        edge_step();
        active_addr = 0; active_data = 1;
        #1;
        chk("h_clear_pend", trans_pend, 1'b0);
        chk("h_clear_trans", HTRANSM, 2'b00);
        chk("h_data_rdy", HREADYOUTS, 1'b1);
        edge_step();
        bus_idle();

        // INCR4 burst, grant lost before beat 2.
        master(1, 2'b10, 32'h3000, 3'd3, 0, 1);
        active_addr = 1;
        edge_step();
        master(1, 2'b11, 32'h3004, 3'd3, 0, 1);
        active_addr = 0; active_data = 1;
        #1;
        chk("b_live_seq", HTRANSM, 2'b11);
        chk("b_req", trans_pend, 1'b1);
        edge_step();
        master(1, 2'b11, 32'h3008, 3'd3, 0, 0);
        active_data = 0;
        #1;
        chk("b_held_trans", HTRANSM, 2'b10);
        chk("b_held_burst", HBURSTM, 3'd1);
        chk("b_held_addr", HADDRM, 32'h3004);
        chk("b_held_rdy", HREADYOUTS, 1'b0);
        active_addr = 1;
        edge_step();
        bus_idle();
        active_data = 1;
        #1;
        chk("b_released", trans_pend, 1'b0);
        edge_step();
        bus_idle();

        // ERROR while a transfer is held; master backs off with IDLE.
        master(1, 2'b10, 32'h4000, 3'd0, 0, 1);
        edge_step();
        master(1, 2'b00, 32'h0, 3'd0, 0, 1);
        active_data = 1; HRESPM = 1; HREADYM = 0;
        #1;
        chk("e_resp1", HRESPS, 1'b1);
        chk("e_rdy1", HREADYOUTS, 1'b0);
        chk("e_pend1", trans_pend, 1'b1);
        edge_step();
        HREADYM = 1;
        #1;
        chk("e_resp2", HRESPS, 1'b1);
        chk("e_pend2", trans_pend, 1'b0);
        chk("e_trans2", HTRANSM, 2'b00);
        chk("e_rdy2", HREADYOUTS, 1'b1);
        edge_step();
        bus_idle();
        #1;
        chk("e_resp_done", HRESPS, 1'b0);
        chk("e_rdy_done", HREADYOUTS, 1'b1);

        // Locked transfer held; live lock drops.
        master(1, 2'b10, 32'h5000, 3'd0, 1, 1);
        edge_step();
        master(1, 2'b00, 32'h0, 3'd0, 0, 0);
        #1;
        chk("l_lock1", HMASTLOCKM, 1'b1);
        edge_step();
        #1;
        chk("l_lock2", HMASTLOCKM, 1'b1);
        active_addr = 1;
        #1;
        chk("l_lock_grant", HMASTLOCKM, 1'b1);
        edge_step();
        active_addr = 0; active_data = 1;
        #1;
        chk("l_lock_live", HMASTLOCKM, 1'b0);
        edge_step();
        bus_idle();

        // BUSY passes through live and is never requested.
        master(1, 2'b01, 32'h7000, 3'd1, 0, 1);
        #1;
        chk("busy_trans", HTRANSM, 2'b01);
        chk("busy_pend", trans_pend, 1'b0);
        edge_step();
        bus_idle();
        #1;
        chk("busy_nohold", trans_pend, 1'b0);

        // Reset asserted mid-hold.
        master(1, 2'b10, 32'h6000, 3'd0, 0, 1);
        edge_step();
        master(0, 2'b00, 32'h0, 3'd0, 0, 0);
        #1;
        chk("r_held", trans_pend, 1'b1);
        HRESETn = 1'b0;
        #1;
        chk("r_trans", HTRANSM, 2'b00);
        chk("r_rdy", HREADYOUTS, 1'b1);
        chk("r_pend", trans_pend, 1'b0);
        edge_step();
        HRESETn = 1'b1;
        HREADYS = 1'b1;
        #1;
        chk("r_after_pend", trans_pend, 1'b0);
        chk("r_after_rdy", HREADYOUTS, 1'b1);
        edge_step();
        #1;
        chk("r_after2_pend", trans_pend, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
